// File: rtl/ph_reg3_sync_if.sv
// Parasite-to-host Register 3 bus bundle: parasite write side, host read side,
// mode/error control and the status/data returned to both sides.
interface ph_reg3_sync_if;
  logic       p_selectData;
  logic       p_we;
  logic [7:0] p_data;
  logic       h_selectData;
  logic       h_rd;
  logic       one_byte_mode;
  logic       err_clr;
  logic [7:0] h_data;
  logic       h_data_available;
  logic       h_two_bytes_available;
  logic       p_full;
  logic       p_overrun;
  logic       h_underrun;

  modport master (
    output p_selectData, p_we, p_data, h_selectData, h_rd, one_byte_mode, err_clr,
    input  h_data, h_data_available, h_two_bytes_available, p_full, p_overrun, h_underrun
  );

  modport slave (
    input  p_selectData, p_we, p_data, h_selectData, h_rd, one_byte_mode, err_clr,
    output h_data, h_data_available, h_two_bytes_available, p_full, p_overrun, h_underrun
  );
endinterface

// File: rtl/ph_reg3_sync.sv
// Parasite-to-host Register 3: two-slot byte FIFO with one-/two-byte modes,
// mode latched only while empty, plus sticky overrun/underrun flags.
module ph_reg3_sync (
  input logic          clk,
  input logic          rst,
  ph_reg3_sync_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, HALF_IN, FULL, HALF_OUT} state_t;

  state_t     st;
  logic [7:0] b0, b1;
  logic       m;
  logic       overrun, underrun;
  logic       wr, rd;
  logic       set_ovr, set_und;

  assign wr = bus.p_selectData & bus.p_we;
  assign rd = bus.h_selectData & bus.h_rd;

  always_comb begin
    set_ovr = 1'b0;
    set_und = 1'b0;
    if (m) begin
      set_und = rd && (st == EMPTY);
      set_ovr = wr && !rd && (st == HALF_IN);
    end else begin
      set_und = rd && (st == EMPTY || st == HALF_IN);
      set_ovr = wr && (st == FULL || st == HALF_OUT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= EMPTY;
      b0       <= '0;
      b1       <= '0;
      m        <= 1'b1;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      overrun  <= set_ovr | (overrun & ~bus.err_clr);
      underrun <= set_und | (underrun & ~bus.err_clr);
      if (st == EMPTY) m <= bus.one_byte_mode;
      if (m) begin
        // One-byte mode: a write always lands in b0; it only leaves HALF_IN on a read-only cycle.
        case (st)
          EMPTY: if (wr) begin
            b0 <= bus.p_data;
            st <= HALF_IN;
          end
          HALF_IN: begin
            if (wr)      b0 <= bus.p_data;
            else if (rd) st <= EMPTY;
          end
          default: st <= EMPTY;
        endcase
      end else begin
        case (st)
          EMPTY: if (wr) begin
            b0 <= bus.p_data;
            st <= HALF_IN;
          end
          HALF_IN: if (wr) begin
            b1 <= bus.p_data;
            st <= FULL;
          end
          FULL:     if (rd) st <= HALF_OUT;
          HALF_OUT: if (rd) st <= EMPTY;
          default:  st <= EMPTY;
        endcase
      end
    end
  end

  logic avail;
  always_comb begin
    avail = m ? (st == HALF_IN) : (st == FULL || st == HALF_OUT);
  end

  assign bus.h_data                = (st == HALF_OUT) ? b1 : b0;
  assign bus.h_data_available      = avail;
  assign bus.p_full                = avail;
  assign bus.h_two_bytes_available = !m && (st == FULL);
  assign bus.p_overrun             = overrun;
  assign bus.h_underrun            = underrun;
endmodule

// File: tb/tb_ph_reg3_sync.sv
// Bench for ph_reg3_sync: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a byte-count model.
module tb_ph_reg3_sync;
  logic clk;
  logic rst;
  ph_reg3_sync_if bus ();

  ph_reg3_sync dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  // Model: bytes written (wcnt) and read back (rcnt) in the current transfer.
  logic [7:0] mb0, mb1;
  int         wcnt, rcnt;
  bit         mm, movr, mund;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit exp_avail();
    return mm ? (wcnt == 1) : (wcnt == 2);
  endfunction

  function automatic logic [7:0] exp_data();
    return (!mm && wcnt == 2 && rcnt == 1) ? mb1 : mb0;
  endfunction

  always @(posedge clk) begin
    bit wr, rd, w_ok, r_ok, o, u;
    wr = bus.p_selectData & bus.p_we;
    rd = bus.h_selectData & bus.h_rd;
    if (rst) begin
      mb0 = 8'h00; mb1 = 8'h00; wcnt = 0; rcnt = 0;
      mm = 1'b1; movr = 1'b0; mund = 1'b0;
    end else begin
      bit nm;
      o = 1'b0; u = 1'b0;
      nm = (wcnt == 0) ? bus.one_byte_mode : mm;
      if (mm) begin
        if (rd && wcnt == 0) u = 1'b1;
        if (wr && wcnt == 1 && !rd) o = 1'b1;
        if (rd && wcnt == 1) wcnt = 0;
        if (wr) begin mb0 = bus.p_data; wcnt = 1; end
      end else begin
        w_ok = (wcnt < 2);
        r_ok = (wcnt == 2);
        if (wr) begin
          if (w_ok) begin
            if (wcnt == 0) mb0 = bus.p_data; else mb1 = bus.p_data;
            wcnt++;
          end else o = 1'b1;
        end
        if (rd) begin
          if (r_ok) begin
            rcnt++;
            if (rcnt == 2) begin wcnt = 0; rcnt = 0; end
          end else u = 1'b1;
        end
      end
      mm   = nm;
      movr = o | (movr & ~bus.err_clr);
      mund = u | (mund & ~bus.err_clr);
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("m_h_data", bus.h_data, exp_data());
      check("m_avail", {7'd0, bus.h_data_available}, {7'd0, exp_avail()});
      check("m_full", {7'd0, bus.p_full}, {7'd0, exp_avail()});
      check("m_two", {7'd0, bus.h_two_bytes_available}, {7'd0, (!mm && wcnt == 2 && rcnt == 0)});
      check("m_overrun", {7'd0, bus.p_overrun}, {7'd0, movr});
      check("m_underrun", {7'd0, bus.h_underrun}, {7'd0, mund});
    end
  end

  task automatic step(input bit w, input bit r, input logic [7:0] d,
                      input bit v, input bit c, input bit rs);
    bus.p_selectData = w; bus.p_we = w; bus.p_data = d;
    bus.h_selectData = r; bus.h_rd = r;
    bus.one_byte_mode = v; bus.err_clr = c; rst = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic flags(input string name, input bit av, input bit two, input bit ov, input bit un);
    check({name, "_avail"}, {7'd0, bus.h_data_available}, {7'd0, av});
    check({name, "_full"}, {7'd0, bus.p_full}, {7'd0, av});
    check({name, "_two"}, {7'd0, bus.h_two_bytes_available}, {7'd0, two});
    check({name, "_ovr"}, {7'd0, bus.p_overrun}, {7'd0, ov});
    check({name, "_und"}, {7'd0, bus.h_underrun}, {7'd0, un});
  endtask

  initial begin
    step(0, 0, 8'h00, 1, 0, 1);
    model_on = 1'b1;
    step(0, 0, 8'h00, 1, 0, 0);
    flags("reset", 0, 0, 0, 0);
    check("reset_data", bus.h_data, 8'h00);

    // Two-byte mode transfer
    step(0, 0, 8'h00, 0, 0, 0);
    step(1, 0, 8'hA5, 0, 0, 0);
    flags("two_w1", 0, 0, 0, 0);
    step(1, 0, 8'h3C, 0, 0, 0);
    flags("two_w2", 1, 1, 0, 0);
    check("two_w2_data", bus.h_data, 8'hA5);
    step(1, 0, 8'h77, 0, 0, 0);
    flags("two_ovr", 1, 1, 1, 0);
    check("two_ovr_data", bus.h_data, 8'hA5);
    step(0, 0, 8'h00, 0, 1, 0);
    flags("two_clr", 1, 1, 0, 0);
    step(0, 1, 8'h00, 0, 0, 0);
    flags("two_r1", 1, 0, 0, 0);
    check("two_r1_data", bus.h_data, 8'h3C);
    step(0, 1, 8'h00, 0, 0, 0);
    flags("two_r2", 0, 0, 0, 0);

    // One-byte mode
    step(0, 0, 8'h00, 1, 0, 0);
    step(1, 0, 8'h11, 1, 0, 0);
    flags("one_w", 1, 0, 0, 0);
    check("one_read_sees", bus.h_data, 8'h11);
    step(1, 1, 8'h22, 1, 0, 0);
    flags("one_rw", 1, 0, 0, 0);
    check("one_rw_data", bus.h_data, 8'h22);
    step(0, 1, 8'h00, 1, 0, 0);
    flags("one_r", 0, 0, 0, 0);
    step(0, 1, 8'h00, 1, 0, 0);
    flags("one_und", 0, 0, 0, 1);
    step(0, 0, 8'h00, 1, 1, 0);
    flags("one_clr", 0, 0, 0, 0);

    // Mode change mid-transfer is deferred until empty
    step(0, 0, 8'h00, 0, 0, 0);
    step(1, 0, 8'h01, 0, 0, 0);
    step(0, 0, 8'h00, 1, 0, 0);
    flags("latch_hold", 0, 0, 0, 0);
    step(1, 0, 8'h02, 1, 0, 0);
    flags("latch_full", 1, 1, 0, 0);
    step(0, 1, 8'h00, 1, 0, 0);
    check("latch_r1_data", bus.h_data, 8'h02);
    step(0, 1, 8'h00, 1, 0, 0);
    flags("latch_r2", 0, 0, 0, 0);
    step(1, 0, 8'h03, 1, 0, 0);
    flags("latch_one", 1, 0, 0, 0);
    check("latch_one_data", bus.h_data, 8'h03);
    step(0, 1, 8'h00, 1, 0, 0);

    // Reset while full with a write strobe
    step(0, 0, 8'h00, 0, 0, 0);
    step(1, 0, 8'hAA, 0, 0, 0);
    step(1, 0, 8'hBB, 0, 0, 0);
    step(1, 0, 8'hCC, 0, 0, 1);
    flags("rst_full", 0, 0, 0, 0);
    check("rst_full_data", bus.h_data, 8'h00);

    // Randomized traffic
    begin
      bit v;
      v = 1'b0;
      for (int unsigned i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 19) == 0) v = ~v;
        step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 8'($urandom),
             v, $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
      end
    end
    step(0, 0, 8'h00, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
